// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/DM memory port arbiter.
// The ARB_ROUND_ROBIN_EN build option is handled in mem_arb_grant.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  // Smallest width (at least 1) able to index 'value' distinct states
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational requester picker for the memory port arbiter.
// Define ARB_ROUND_ROBIN_EN for alternating grants on ties; otherwise DM always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic    i_if_valid,
  input  logic    i_dm_valid,
  input  req_id_e i_last_served,
  output logic    o_grant_valid,
  output req_id_e o_grant_id
);

  assign o_grant_valid = i_if_valid | i_dm_valid;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the requester that was not served last wins
  always_comb begin
    o_grant_id = REQ_IF;
    if (i_if_valid && i_dm_valid) begin
      if (i_last_served == REQ_IF) o_grant_id = REQ_DM;
      else                         o_grant_id = REQ_IF;
    end else if (i_dm_valid) begin
      o_grant_id = REQ_DM;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_served;

  always_comb begin
    o_grant_id = REQ_IF;
    if (i_dm_valid) o_grant_id = REQ_DM;
  end
`endif

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data memory requesters.
// Tie-break policy selected by ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LATENCY);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("memory_port_arbiter: MEM_LATENCY must be >= 1");
    end
  endgenerate

  arb_state_e        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  req_id_e           r_owner, r_last_served, w_grant_id;
  logic              r_is_write;
  logic              w_grant_valid, w_idle, w_if_hs, w_dm_hs, w_dm_write, w_accept, w_last_beat;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rsp_data, r_dm_rsp_data;
  logic              r_mem_re, r_mem_we, r_if_rsp_valid, r_dm_rsp_valid;

  mem_arb_grant u_grant (
    .i_if_valid    (if_req_valid),
    .i_dm_valid    (dm_req_valid),
    .i_last_served (r_last_served),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // Ready is gated by rst_n so every output reads 0 while reset is held
  assign w_idle       = rst_n && (r_state == IDLE);
  assign if_req_ready = w_idle && w_grant_valid && (w_grant_id == REQ_IF);
  assign dm_req_ready = w_idle && w_grant_valid && (w_grant_id == REQ_DM);
  assign w_if_hs      = if_req_valid && if_req_ready;
  assign w_dm_hs      = dm_req_valid && dm_req_ready;
  assign w_dm_write   = w_dm_hs && dm_we;
  assign w_accept     = w_if_hs || w_dm_hs;
  assign w_last_beat  = (r_state == BUSY) && (r_cnt == LAT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept)    w_next_state = BUSY;
      BUSY: if (w_last_beat) w_next_state = IDLE;
    endcase
  end

  // Capture on handshake, hold through BUSY, respond on the edge that leaves BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_owner        <= REQ_IF;
      r_last_served  <= REQ_IF;
      r_is_write     <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_re       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_data  <= '0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_cnt         <= CNT_W'(1);
        r_owner       <= w_grant_id;
        r_last_served <= w_grant_id;
        r_is_write    <= w_dm_write;
        r_mem_addr    <= w_dm_hs ? dm_addr : if_addr;
        r_mem_wdata   <= w_dm_write ? dm_wdata : '0;
        r_mem_re      <= !w_dm_write;
        r_mem_we      <= w_dm_write;
      end else if (r_state == BUSY) begin
        r_mem_we <= 1'b0;
        if (w_last_beat) begin
          r_cnt       <= '0;
          r_mem_re    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          if (r_owner == REQ_IF) begin
            r_if_rsp_valid <= 1'b1;
            r_if_rsp_data  <= mem_rdata;
          end else begin
            r_dm_rsp_valid <= 1'b1;
            if (!r_is_write) r_dm_rsp_data <= mem_rdata;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_re       = r_mem_re;
  assign mem_we       = r_mem_we;
  assign mem_wdata    = r_mem_wdata;
  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_data  = r_if_rsp_data;
  assign dm_rsp_valid = r_dm_rsp_valid;
  assign dm_rsp_data  = r_dm_rsp_data;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: one instance at MEM_LATENCY=1, one at 3.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating tie-break.
`timescale 1ns/1ps
module tb_memory_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req_valid, if_req_ready, if_rsp_valid, dm_req_valid, dm_req_ready, dm_we, dm_rsp_valid, mem_re, mem_we;
  logic [31:0] if_addr, if_rsp_data, dm_addr, dm_wdata, dm_rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic        if_req_valid_b, if_req_ready_b, if_rsp_valid_b, dm_req_valid_b, dm_req_ready_b, dm_we_b, dm_rsp_valid_b, mem_re_b, mem_we_b;
  logic [31:0] if_addr_b, if_rsp_data_b, dm_addr_b, dm_wdata_b, dm_rsp_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q_if[$], q_dm[$], q_if_b[$];
  logic [31:0] dm_last = 32'h0;
  int we_cycles = 0, re_starts = 0, re_starts_b = 0;
  logic re_prev = 1'b0, re_prev_b = 1'b0;

  memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
    .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid_b), .if_req_ready(if_req_ready_b), .if_addr(if_addr_b),
    .if_rsp_valid(if_rsp_valid_b), .if_rsp_data(if_rsp_data_b),
    .dm_req_valid(dm_req_valid_b), .dm_req_ready(dm_req_ready_b), .dm_addr(dm_addr_b),
    .dm_we(dm_we_b), .dm_wdata(dm_wdata_b), .dm_rsp_valid(dm_rsp_valid_b), .dm_rsp_data(dm_rsp_data_b),
    .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Power-up memory contents; locations never written read back this pattern
  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hDEAD_BEEF;
      32'h0000_0000: return 32'hA0A0_0000;
      32'h0000_0004: return 32'hB4B4_0004;
      default:       return {24'hC0FFEE, a[7:0]};
    endcase
  endfunction

  logic [31:0]  mem_a [0:255];
  logic [255:0] wr_a = '0;

  always_comb begin
    mem_rdata = wr_a[mem_addr[9:2]] ? mem_a[mem_addr[9:2]] : init_val(mem_addr);
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem_a[mem_addr[9:2]] <= mem_wdata;
      wr_a[mem_addr[9:2]]  <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata_b = init_val(mem_addr_b);
  end

  // Response scoreboard: pop and compare on every response pulse
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (if_rsp_valid) begin
      vectors++;
      if (q_if.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL if_rsp_unexpected got=%h expected=none", if_rsp_data);
      end else begin
        e = q_if.pop_front();
        if (if_rsp_data !== e) begin
          miscompares++;
          $display("[TB] FAIL if_rsp_data got=%h expected=%h", if_rsp_data, e);
        end
      end
    end
    if (dm_rsp_valid) begin
      vectors++;
      if (q_dm.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL dm_rsp_unexpected got=%h expected=none", dm_rsp_data);
      end else begin
        e = q_dm.pop_front();
        if (dm_rsp_data !== e) begin
          miscompares++;
          $display("[TB] FAIL dm_rsp_data got=%h expected=%h", dm_rsp_data, e);
        end
      end
    end
    if (if_rsp_valid_b) begin
      vectors++;
      if (q_if_b.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL if_rsp_b_unexpected got=%h expected=none", if_rsp_data_b);
      end else begin
        e = q_if_b.pop_front();
        if (if_rsp_data_b !== e) begin
          miscompares++;
          $display("[TB] FAIL if_rsp_b_data got=%h expected=%h", if_rsp_data_b, e);
        end
      end
    end
    if (dm_rsp_valid_b) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL dm_rsp_b_unexpected got=%h expected=none", dm_rsp_data_b);
    end
    if (mem_we) we_cycles++;
    if (mem_re && !re_prev) re_starts++;
    if (mem_re_b && !re_prev_b) re_starts_b++;
    re_prev   = mem_re;
    re_prev_b = mem_re_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 1'b0; if_addr = '0; dm_req_valid = 1'b0; dm_addr = '0; dm_we = 1'b0; dm_wdata = '0;
    if_req_valid_b = 1'b0; if_addr_b = '0; dm_req_valid_b = 1'b0; dm_addr_b = '0; dm_we_b = 1'b0; dm_wdata_b = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    dm_last = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int pulses;
    clear_inputs();
    tick();
    vectors++;
    if ({mem_addr, mem_re, mem_we, mem_wdata, if_rsp_valid, if_rsp_data, dm_rsp_valid, dm_rsp_data, if_req_ready, dm_req_ready} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=nonzero expected=all_zero");
    end
    rst_n = 1'b1;
    tick();
    dm_req_valid = 1'b1; dm_addr = 32'h40; dm_we = 1'b0;
    #1;
    vectors++;
    if (dm_req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_dm_ready got=%b expected=1", dm_req_ready);
    end
    tick();
    dm_req_valid = 1'b0;
    vectors++;
    if ({mem_re, mem_addr} !== {1'b1, 32'h40}) begin
      miscompares++;
      $display("[TB] FAIL reset_busy_read got=%b/%h expected=1/00000040", mem_re, mem_addr);
    end
    #2;
    rst_n = 1'b0;
    dm_req_valid = 1'b1;
    #1;
    vectors++;
    if ({mem_addr, mem_re, mem_we, mem_wdata, if_rsp_valid, dm_rsp_valid, dm_rsp_data, if_req_ready, dm_req_ready} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_busy got=nonzero re=%b addr=%h rdy=%b expected=all_zero", mem_re, mem_addr, dm_req_ready);
    end
    dm_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dm_rsp_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_rsp got=%0d expected=0", pulses);
    end
  endtask

  task automatic test_if_read();
    if_req_valid = 1'b1; if_addr = 32'h10;
    q_if.push_back(32'hDEAD_BEEF);
    #1;
    vectors++;
    if ({if_req_ready, dm_req_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL if_read_ready got=%b%b expected=10", if_req_ready, dm_req_ready);
    end
    tick();
    if_req_valid = 1'b0;
    vectors++;
    if ({mem_re, mem_we, mem_addr, if_rsp_valid} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL if_read_busy got=re%b we%b %h rsp%b expected=re1 we0 00000010 rsp0", mem_re, mem_we, mem_addr, if_rsp_valid);
    end
    tick();
    vectors++;
    if ({if_rsp_valid, mem_re, mem_addr} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL if_read_rsp got=rsp%b re%b %h expected=rsp1 re0 00000000", if_rsp_valid, mem_re, mem_addr);
    end
    tick();
    vectors++;
    if (if_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL if_read_pulse got=%b expected=0", if_rsp_valid);
    end
  endtask

  task automatic test_dm_write_read();
    int we_start;
    we_start = we_cycles;
    dm_req_valid = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
    q_dm.push_back(dm_last);
    #1;
    vectors++;
    if (dm_req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dm_write_ready got=%b expected=1", dm_req_ready);
    end
    tick();
    dm_req_valid = 1'b0; dm_we = 1'b0;
    vectors++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h80, 32'h1234_5678}) begin
      miscompares++;
      $display("[TB] FAIL dm_write_strobe got=we%b re%b %h %h expected=we1 re0 00000080 12345678", mem_we, mem_re, mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if ({mem_we, dm_rsp_valid} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL dm_write_ack got=we%b ack%b expected=we0 ack1", mem_we, dm_rsp_valid);
    end
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    q_dm.push_back(32'h1234_5678);
    dm_last = 32'h1234_5678;
    #1;
    vectors++;
    if (dm_req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dm_read_ready got=%b expected=1", dm_req_ready);
    end
    tick();
    dm_req_valid = 1'b0;
    vectors++;
    if ({mem_re, mem_we} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL dm_read_busy got=re%b we%b expected=re1 we0", mem_re, mem_we);
    end
    tick();
    vectors++;
    if (dm_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dm_read_rsp got=%b expected=1", dm_rsp_valid);
    end
    vectors++;
    if (we_cycles - we_start !== 1) begin
      miscompares++;
      $display("[TB] FAIL dm_we_cycles got=%0d expected=1", we_cycles - we_start);
    end
  endtask

  task automatic test_contention();
    int exp_id, got_id;
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h10;
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = (k % 2 == 0) ? 1 : 0;
`else
      exp_id = 1;
`endif
      vectors++;
      if (if_req_ready && dm_req_ready) begin
        miscompares++;
        $display("[TB] FAIL contention_both_ready got=11 expected=one_hot");
      end
      got_id = dm_req_ready ? 1 : (if_req_ready ? 0 : 2);
      vectors++;
      if (got_id !== exp_id) begin
        miscompares++;
        $display("[TB] FAIL contention_grant_%0d got=%0d expected=%0d (0=IF 1=DM)", k, got_id, exp_id);
      end
      if (got_id == 1) begin
        q_dm.push_back(32'h1234_5678);
        dm_last = 32'h1234_5678;
      end else if (got_id == 0) begin
        q_if.push_back(32'hDEAD_BEEF);
      end
      tick();
      vectors++;
      if ({if_req_ready, dm_req_ready} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL contention_busy_ready got=%b%b expected=00", if_req_ready, dm_req_ready);
      end
      if (k == 3) begin
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_bits, got_bits;
    logic [31:0] exp_addr;
    int          re_start;
    re_start = re_starts_b;
    if_req_valid_b = 1'b1; if_addr_b = 32'h0;
    q_if_b.push_back(32'hA0A0_0000);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) if_addr_b = 32'h4;
      if (c == 4) q_if_b.push_back(32'hB4B4_0004);
      if (c == 5) if_req_valid_b = 1'b0;
      #1;
      exp_bits[2] = (c == 0) || (c == 4);
      exp_bits[1] = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      exp_bits[0] = (c == 4) || (c == 8);
      exp_addr    = (c >= 5 && c <= 7) ? 32'h4 : 32'h0;
      got_bits    = {if_req_ready_b, mem_re_b, if_rsp_valid_b};
      vectors++;
      if ({got_bits, mem_addr_b} !== {exp_bits, exp_addr}) begin
        miscompares++;
        $display("[TB] FAIL lat3_cycle_%0d got=rdy/re/rsp %b addr %h expected=%b addr %h", c, got_bits, mem_addr_b, exp_bits, exp_addr);
      end
      tick();
    end
    vectors++;
    if (re_starts_b - re_start !== 2) begin
      miscompares++;
      $display("[TB] FAIL lat3_access_count got=%0d expected=2", re_starts_b - re_start);
    end
  endtask

  task automatic test_valid_during_busy();
    logic [1:0] exp_bits, got_bits;
    int         re_start;
    re_start = re_starts;
    if_req_valid = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) if_req_valid = 1'b0;
      if (c < 5 && c % 2 == 0) q_if.push_back(32'hDEAD_BEEF);
      #1;
      exp_bits[1] = (c < 5) && (c % 2 == 0);
      exp_bits[0] = (c == 2) || (c == 4) || (c == 6);
      got_bits    = {if_req_ready, if_rsp_valid};
      vectors++;
      if (got_bits !== exp_bits) begin
        miscompares++;
        $display("[TB] FAIL busy_hold_cycle_%0d got=rdy/rsp %b expected=%b", c, got_bits, exp_bits);
      end
      tick();
    end
    vectors++;
    if (re_starts - re_start !== 3) begin
      miscompares++;
      $display("[TB] FAIL busy_hold_access_count got=%0d expected=3", re_starts - re_start);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_if.size() + q_dm.size() + q_if_b.size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if ((q_if.size() + q_dm.size() + q_if_b.size()) != 0) begin
      miscompares++;
      $display("[TB] FAIL drain got=%0d pending expected=0", q_if.size() + q_dm.size() + q_if_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write_read();
    drain();
    test_contention();
    drain();
    test_back_to_back();
    test_valid_during_busy();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
